// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// ALU opcodes, FSM state encoding and the ALU instruction-word builder.
package alu_mul_pkg;

  localparam int unsigned OPC_W      = 5;
  localparam int unsigned INSN_MAX_W = 64;

  localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SDRH = 5'b01110;
  localparam logic [OPC_W-1:0] OP_SDRL = 5'b01111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SDRL = 3'd2,
    S_SDRH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Left-justified {opcode, zeros}; callers keep the top INSN+1 bits.
  function automatic logic [INSN_MAX_W-1:0] insn_word(input logic [OPC_W-1:0] op);
    return {op, {(INSN_MAX_W-OPC_W){1'b0}}};
  endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bundle between the multiplier controller, the upstream scheduler and the
// shared ALU.
//   i_start/i_a/i_b          : start request and operands (scheduler -> mul)
//   o_busy/o_done/o_prod_*   : status and product (mul -> scheduler)
//   o_alu_insn/r1/r2/carry   : ALU operation (mul -> ALU)
//   i_alu_result             : combinational ALU result (ALU -> mul)
interface alu_mul_seq_if #(
  parameter int unsigned WORD_SIZE = 256,
  parameter int unsigned INSN      = 19
);

  logic                 i_start;
  logic [WORD_SIZE-1:0] i_a;
  logic [WORD_SIZE-1:0] i_b;
  logic                 o_busy;
  logic                 o_done;
  logic [WORD_SIZE-1:0] o_prod_hi;
  logic [WORD_SIZE-1:0] o_prod_lo;
  logic [INSN:0]        o_alu_insn;
  logic [WORD_SIZE-1:0] o_alu_r1data;
  logic [WORD_SIZE-1:0] o_alu_r2data;
  logic                 o_alu_carry;
  logic [WORD_SIZE-1:0] i_alu_result;

  modport slave (
    input  i_start, i_a, i_b, i_alu_result,
    output o_busy, o_done, o_prod_hi, o_prod_lo,
           o_alu_insn, o_alu_r1data, o_alu_r2data, o_alu_carry
  );

  modport master (
    output i_start, i_a, i_b, i_alu_result,
    input  o_busy, o_done, o_prod_hi, o_prod_lo,
           o_alu_insn, o_alu_r1data, o_alu_r2data, o_alu_carry
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier controller. Sequences the shared
// WORD_SIZE-bit ALU (ADD / SDRL / SDRH) to build a 2*WORD_SIZE-bit unsigned
// product of i_a and i_b.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : start/busy/done handshake, product and ALU drive (slave side)
// ALU drive signals are registered from the next-state values, so the ALU
// sees the operation for the state being entered on the same edge.
module alu_mul_seq
  import alu_mul_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 256,
  parameter int unsigned INSN      = 19,
  parameter int unsigned CNT_W     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mul_seq_if.slave  bus
);

  localparam int unsigned INSN_W = INSN + 1;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] hi_q, hi_d;
  logic [WORD_SIZE-1:0] lo_q, lo_d;
  logic [WORD_SIZE-1:0] m_q, m_d;
  logic                 carry_q, carry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WORD_SIZE-1:0] prod_hi_q, prod_hi_d;
  logic [WORD_SIZE-1:0] prod_lo_q, prod_lo_d;
  logic [INSN_W-1:0]    insn_q, insn_d;
  logic [WORD_SIZE-1:0] r1_q, r1_d;
  logic [WORD_SIZE-1:0] r2_q, r2_d;

  // Truncate the package's left-justified insn word to this ALU's width.
  function automatic logic [INSN_W-1:0] mk_insn(input logic [OPC_W-1:0] op);
    logic [INSN_MAX_W-1:0] w;
    w = insn_word(op);
    return w[INSN_MAX_W-1 -: INSN_W];
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      insn_q    <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      insn_q    <= insn_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
    end
  end

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    insn_d    = mk_insn(OP_NOP);
    r1_d      = '0;
    r2_d      = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          m_d     = bus.i_a;
          lo_d    = bus.i_b;
          hi_d    = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = bus.i_b[0] ? S_ADD : S_SDRL;
        end
      end
      S_ADD: begin
        hi_d    = bus.i_alu_result;
        // Unsigned wrap of hi + m means the add carried out.
        carry_d = (bus.i_alu_result < hi_q);
        state_d = S_SDRL;
      end
      S_SDRL: begin
        lo_d    = bus.i_alu_result;
        state_d = S_SDRH;
      end
      S_SDRH: begin
        // Carry from the preceding ADD becomes the new MSB of hi.
        hi_d    = {carry_q, bus.i_alu_result[WORD_SIZE-2:0]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WORD_SIZE - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = lo_q[0] ? S_ADD : S_SDRL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs registered for the state being entered.
    case (state_d)
      S_ADD: begin
        insn_d = mk_insn(OP_ADD);
        r1_d   = hi_d;
        r2_d   = m_d;
        busy_d = 1'b1;
      end
      S_SDRL: begin
        insn_d = mk_insn(OP_SDRL);
        r1_d   = hi_d;
        r2_d   = lo_d;
        busy_d = 1'b1;
      end
      S_SDRH: begin
        insn_d = mk_insn(OP_SDRH);
        r1_d   = hi_d;
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d    = 1'b1;
        prod_hi_d = hi_d;
        prod_lo_d = lo_d;
      end
      default: begin
        insn_d = mk_insn(OP_NOP);
      end
    endcase
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_prod_hi    = prod_hi_q;
  assign bus.o_prod_lo    = prod_lo_q;
  assign bus.o_alu_insn   = insn_q;
  assign bus.o_alu_r1data = r1_q;
  assign bus.o_alu_r2data = r2_q;
  assign bus.o_alu_carry  = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: an 8-bit and a 256-bit instance, each driving a
// behavioural ALU; expected products are queued at start and compared at done.
module tb_alu_mul_seq;
  import alu_mul_pkg::*;

  localparam int unsigned INSN = 19;
  localparam int unsigned W8   = 8;
  localparam int unsigned W256 = 256;
  localparam logic [INSN:0] INSN_ADD = {OP_ADD, {(INSN-4){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.WORD_SIZE(W8),   .INSN(INSN)) bus8   ();
  alu_mul_seq_if #(.WORD_SIZE(W256), .INSN(INSN)) bus256 ();

  alu_mul_seq #(.WORD_SIZE(W8), .INSN(INSN), .CNT_W(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  alu_mul_seq #(.WORD_SIZE(W256), .INSN(INSN), .CNT_W(9)) u_dut256 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus256.slave)
  );

  // Behavioural LC4-style ALU subset.
  always_comb begin
    case (bus8.o_alu_insn[INSN -: 5])
      OP_ADD:  bus8.i_alu_result = bus8.o_alu_r1data + bus8.o_alu_r2data;
      OP_SDRL: bus8.i_alu_result = {bus8.o_alu_r1data[0], bus8.o_alu_r2data[W8-1:1]};
      OP_SDRH: bus8.i_alu_result = {1'b0, bus8.o_alu_r1data[W8-1:1]};
      default: bus8.i_alu_result = '0;
    endcase
  end

  always_comb begin
    case (bus256.o_alu_insn[INSN -: 5])
      OP_ADD:  bus256.i_alu_result = bus256.o_alu_r1data + bus256.o_alu_r2data;
      OP_SDRL: bus256.i_alu_result = {bus256.o_alu_r1data[0], bus256.o_alu_r2data[W256-1:1]};
      OP_SDRH: bus256.i_alu_result = {1'b0, bus256.o_alu_r1data[W256-1:1]};
      default: bus256.i_alu_result = '0;
    endcase
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0]  sb8[$];
  logic [511:0] sb256[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation; returns in the IDLE cycle following DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int cyc;
    int exp_lat;
    int c;
    int busy_err;
    int prod_err;
    bit got;
    logic [63:0] add_mask;
    logic [63:0] exp_mask;
    logic [15:0] prod0;
    logic [15:0] exp_p;
    prod0   = {bus8.o_prod_hi, bus8.o_prod_lo};
    exp_lat = 2 * 8 + $countones(b) + 1;
    exp_mask = '0;
    c = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        exp_mask[c] = 1'b1;
        c += 3;
      end else begin
        c += 2;
      end
    end
    bus8.i_start = 1'b1;
    bus8.i_a     = a;
    bus8.i_b     = b;
    sb8.push_back(16'(a) * 16'(b));
    cyc = 0; got = 1'b0; add_mask = '0; busy_err = 0; prod_err = 0;
    while (!got && cyc < 63) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) begin
        bus8.i_start = 1'b0;
      end else begin
        bus8.i_a = 8'($urandom);
        bus8.i_b = 8'($urandom);
      end
      if (bus8.o_alu_insn == INSN_ADD) add_mask[cyc] = 1'b1;
      if (bus8.o_done) begin
        got = 1'b1;
      end else begin
        if (bus8.o_busy !== 1'b1) busy_err++;
        if ({bus8.o_prod_hi, bus8.o_prod_lo} !== prod0) prod_err++;
      end
    end
    exp_p = sb8.pop_front();
    chk("done_seen",    512'(got), 512'(1));
    chk("latency",      512'(cyc), 512'(exp_lat));
    chk("add_cycles",   512'(add_mask), 512'(exp_mask));
    chk("busy_window",  512'(busy_err), 512'(0));
    chk("prod_stable",  512'(prod_err), 512'(0));
    chk("product",      512'({bus8.o_prod_hi, bus8.o_prod_lo}), 512'(exp_p));
    chk("busy_in_done", 512'(bus8.o_busy), 512'(0));
    @(posedge clk); #1;
    chk("done_pulse",   512'(bus8.o_done), 512'(0));
    chk("idle_busy",    512'(bus8.o_busy), 512'(0));
    chk("idle_insn",    512'(bus8.o_alu_insn), 512'(0));
    chk("prod_held",    512'({bus8.o_prod_hi, bus8.o_prod_lo}), 512'(exp_p));
  endtask

  initial begin
    int cyc;
    int dones;
    bit got;
    logic [511:0] exp_w;
    logic [W256-1:0] ones;

    bus8.i_start = 1'b0; bus8.i_a = '0; bus8.i_b = '0;
    bus256.i_start = 1'b0; bus256.i_a = '0; bus256.i_b = '0;

    // Reset state of both instances.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst8_busy", 512'(bus8.o_busy), 512'(0));
    chk("rst8_done", 512'(bus8.o_done), 512'(0));
    chk("rst8_prod", 512'({bus8.o_prod_hi, bus8.o_prod_lo}), 512'(0));
    chk("rst8_insn", 512'(bus8.o_alu_insn), 512'(0));
    chk("rst8_ops",  512'({bus8.o_alu_r1data, bus8.o_alu_r2data, bus8.o_alu_carry}), 512'(0));
    chk("rst256_prod", {bus256.o_prod_hi, bus256.o_prod_lo}, 512'(0));
    chk("rst256_ctl", 512'({bus256.o_busy, bus256.o_done, bus256.o_alu_insn}), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed 8-bit cases.
    op8(8'h0F, 8'h03, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'hA5, 8'h00, 1'b0);

    // Start held high with operands scrambled mid-operation: back-to-back.
    op8(8'h9C, 8'h6B, 1'b1);
    op8(8'hC3, 8'h81, 1'b1);
    op8(8'h5A, 8'hE7, 1'b0);

    for (int k = 0; k < 3; k++) begin
      op8(8'($urandom), 8'($urandom), 1'b0);
    end
    op8(8'hFF, 8'hFF, 1'b0);

    // Reset during cycle 6 of an operation.
    bus8.i_start = 1'b1; bus8.i_a = 8'h55; bus8.i_b = 8'h33;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      bus8.i_start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 512'(bus8.o_busy), 512'(0));
    chk("abort_done", 512'(bus8.o_done), 512'(0));
    chk("abort_prod", 512'({bus8.o_prod_hi, bus8.o_prod_lo}), 512'(0));
    chk("abort_insn", 512'(bus8.o_alu_insn), 512'(0));
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus8.o_done) dones++;
    end
    chk("abort_no_done", 512'(dones), 512'(0));
    op8(8'h03, 8'h05, 1'b0);

    // Full-width 256-bit all-ones.
    ones = '1;
    bus256.i_start = 1'b1; bus256.i_a = ones; bus256.i_b = ones;
    sb256.push_back(512'(ones) * 512'(ones));
    cyc = 0; got = 1'b0;
    while (!got && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      bus256.i_start = 1'b0;
      if (bus256.o_done) got = 1'b1;
    end
    exp_w = sb256.pop_front();
    chk("w256_done", 512'(got), 512'(1));
    chk("w256_latency", 512'(cyc), 512'(769));
    chk("w256_product", {bus256.o_prod_hi, bus256.o_prod_lo}, exp_w);
    @(posedge clk); #1;
    chk("w256_done_pulse", 512'(bus256.o_done), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle shift-and-add multiplier controller. It sequences the shared WORD_SIZE-bit LC4-style ALU to form a full 2*WORD_SIZE-bit unsigned product of two operands. It sits beside the ALU in the ECC field-arithmetic path and drives the ALU insn, r1data, r2data and carry inputs. It owns the hi, lo, multiplicand and carry registers and exposes a start/busy/done handshake to the upstream scheduler.

Parameters:
WORD_SIZE, 256, operand width and ALU datapath width
INSN, 19, MSB index of the ALU insn word (insn is INSN+1 bits)
CNT_W, 9, iteration counter width; must satisfy 2^CNT_W > WORD_SIZE

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
i_start  in  1  start request; accepted only in IDLE
i_a  in  WORD_SIZE  multiplicand; sampled on accepted start
i_b  in  WORD_SIZE  multiplier; sampled on accepted start
o_busy  out  1  high from the cycle after accept until the cycle before DONE, inclusive
o_done  out  1  one-cycle pulse; product valid
o_prod_hi  out  WORD_SIZE  upper product half; held until the next accepted start
o_prod_lo  out  WORD_SIZE  lower product half; held until the next accepted start
o_alu_insn  out  INSN+1  {opcode[4:0], zeros}; opcode in [INSN:INSN-4]
o_alu_r1data  out  WORD_SIZE  ALU rs operand
o_alu_r2data  out  WORD_SIZE  ALU rt operand
o_alu_carry  out  1  constant 0
i_alu_result  in  WORD_SIZE  combinational ALU result for the current cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset (rst_n=0 at a clk edge): state goes to IDLE. hi, lo, m, carry and counter clear to 0. o_busy=0, o_done=0, o_prod_hi=0, o_prod_lo=0. o_alu_insn=NOP (all zeros). r1data and r2data are 0.
- Reset mid-operation aborts immediately. No done pulse is produced; the product reads 0.
- Opcodes: NOP 00000, ADD 00101, SDRH 01110, SDRL 01111.
- States: IDLE, ADD, SDRL, SDRH, DONE.
- IDLE:
  - ALU gets NOP.
  - On i_start=1: m<=i_a, lo<=i_b, hi<=0, carry<=0, cnt<=0.
  - Next state is ADD if i_b[0]=1, else SDRL.
- ADD:
  - Drive insn=ADD, r1=hi, r2=m.
  - hi<=i_alu_result.
  - carry<=(i_alu_result < hi) as an unsigned compare, i.e. the carry-out of the add.
  - Next state is SDRL.
- SDRL:
  - Drive insn=SDRL, r1=hi, r2=lo.
  - lo<=i_alu_result, which equals {hi[0], lo[W-1:1]}.
  - Next state is SDRH.
- SDRH:
  - Drive insn=SDRH, r1=hi, r2=0.
  - hi<={carry, i_alu_result[W-2:0]}, i.e. the ALU result with carry injected at the MSB.
  - carry<=0, cnt<=cnt+1.
  - If cnt==WORD_SIZE-1, next state is DONE.
  - Otherwise next state is ADD if the updated lo[0]=1, else SDRL.
- DONE:
  - o_prod_hi<=hi, o_prod_lo<=lo; o_done=1 for this cycle only.
  - Next state is IDLE.
- The ALU result is used combinationally within the same cycle. There is no ALU pipeline latency.
- Latency: start is accepted in cycle 0. Execution occupies cycles 1..2W+popcount(b). o_done is high in cycle 2W+popcount(b)+1.
- o_busy is high in exactly the execution cycles.
- i_start while not IDLE (including DONE) is ignored. Operands are never resampled mid-operation.
- i_start is accepted in the IDLE cycle immediately after DONE (back-to-back operation).
- b=0: no ADD states occur; latency is 2W+1 and the product is 0.
- All-ones operands: carry must be preserved across ADD→SDRH; the full-width product is exact.
- o_prod_* do not change during an operation. They update only in DONE.

Decomposition:
- Shared package `alu_mul_pkg`:
  - ALU opcode constants OP_NOP, OP_ADD, OP_SDRH, OP_SDRL.
  - State encoding constants S_IDLE, S_ADD, S_SDRL, S_SDRH, S_DONE (3 bits).
  - Insn-builder function {op, zeros}.
- No sub-module: the FSM, registers and compare are one block. The ALU is instantiated by the parent, not inside this block.

Test Plan:
- WORD_SIZE=8, a=0x0F, b=0x03, start pulse → ADD issued in cycles 1 and 4. o_done in cycle 19. Product hi=0x00, lo=0x2D.
- WORD_SIZE=8, a=0xFF, b=0xFF → 8 ADDs with carry set. o_done in cycle 25. Product hi=0xFE, lo=0x01.
- WORD_SIZE=8, a=0xA5, b=0x00 → no ADD opcode ever on o_alu_insn. o_done in cycle 17. Product 0x0000.
- WORD_SIZE=8: i_start held high through the whole operation → exactly one done pulse per accepted start. Second accept occurs the cycle after DONE. Operands change mid-op with no effect on the result.
- rst_n=0 at cycle 6 of an operation → next cycle IDLE, busy=0, prod=0, insn=NOP. No done pulse. A fresh start (a=0x03, b=0x05) then yields 0x000F.
- WORD_SIZE=256, a=b=2^256-1 → hi=2^256-2, lo=1. o_done in cycle 769.
